mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  - Multi-cycle multiply/divide unit (XALU) in the EX stage; owns the HI/LO registers.
//  - Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and serves MFHI/MFLO reads.
//  - Drives the busy flag that the hazard/stall logic combines with the D-stage usingXALU bit.
//  - Stalls D on any HI/LO-touching instruction while an operation is in flight.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles after a multiply start (must be >=1)
//  DIV_CYCLES   10  busy cycles after a divide start (must be >=1)
// PORTS
//  clk     in   1      clock, all state updates on rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      qualifies op this cycle; ignored while busy_q=1
//  op      in   4      0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB,10 MSUBU
//  a       in   WIDTH  rs operand
//  b       in   WIDTH  rt operand
//  busy    out  1      start&is_arith(op) | busy_q (combinational)
//  hi      out  WIDTH  HI register (MFHI source)
//  lo      out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy_q=0, cnt=0, pending result=0; busy=0 when start=0.
//  - Idle + start + arith op (1-4, 7-10, when enabled):
//    - Compute the result at that edge into pend_hi/pend_lo.
//    - Load cnt=MULT_CYCLES (mult/madd/msub) or DIV_CYCLES (div); set busy_q=1.
//  - Each busy edge decrements cnt. At the edge with cnt==1: hi<=pend_hi, lo<=pend_lo, cnt=0, busy_q=0.
//  - Timing: start sampled at edge T -> busy_q high cycles T+1..T+N -> new hi/lo visible from T+N+1.
//  - busy output is high N+1 cycles (start cycle plus N).
//  - MULT: {hi,lo} = signed a*b, 2*WIDTH bits. MULTU: unsigned a*b.
//  - DIV: lo = signed a/b truncated toward zero; hi = remainder, sign follows a.
//  - DIVU: unsigned quotient and remainder.
//  - Divide by zero (b==0): still busy DIV_CYCLES; hi/lo left unchanged at commit.
//  - Signed DIV of 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
//  - MTHI/MTLO with start while idle: hi (or lo) <= a at that edge; no busy; busy output 0.
//  - start while busy_q=1: op ignored entirely; in-flight op unaffected. Stall logic prevents this.
//  - op NONE or undefined code with start: no effect.
//  - Reset mid-operation: cancels the op; no commit; all state returns to reset values next cycle.
//  - hi/lo are pure register outputs; no bypass of pending results.
// CONFIGURATION
//  - Macro MDU_MADD_EN:
//    - Defined: ops 7-10 are legal and use MULT_CYCLES.
//      - MADD/MADDU: {hi,lo} += a*b, signed/unsigned product, 64-bit add.
//      - MSUB/MSUBU: {hi,lo} -= a*b.
//      - Accumulate base is the {hi,lo} value at the start edge; wraps modulo 2^(2*WIDTH).
//    - Undefined: ops 7-10 behave as NONE; busy stays 0; no accumulator adder is synthesized.
// TESTING
//  - MULT a=0xFFFFFFFE (-2), b=3 -> busy 6 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at T+6.
//  - DIV a=-7 (0xFFFFFFF9), b=2 -> busy 11 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  - DIVU a=7, b=0 with prior hi=0x11, lo=0x22 -> busy 11 cycles; hi/lo stay 0x11/0x22.
//  - DIV start, then reset at T+4 -> busy 0, hi=lo=0 from T+5; no late commit at T+11.
//  - MTLO a=0x1234 -> lo=0x1234 next cycle, busy never set. MULT start, then MTHI at T+2 -> MTHI ignored.
//  - MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0. Without the macro: unchanged, busy 0.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and result bundle between the EX-stage issue logic and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is computed at issue and committed after a fixed latency.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [2*WIDTH-1:0] mul_signed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] xs, ys;
    xs = signed'({{WIDTH{x[WIDTH-1]}}, x});
    ys = signed'({{WIDTH{y[WIDTH-1]}}, y});
    return xs * ys;
  endfunction

  function automatic logic [2*WIDTH-1:0] mul_unsigned(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xu, yu;
    xu = {{WIDTH{1'b0}}, x};
    yu = {{WIDTH{1'b0}}, y};
    return xu * yu;
  endfunction

  // Returns {remainder, quotient}; the MIN/-1 case wraps instead of trapping.
  function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] sn, sd, q, r;
    sn = signed'(n);
    sd = signed'(d);
    if (d == '0) begin
      q = '0;
      r = '0;
    end else if (n == MIN_NEG && d == '1) begin
      q = sn;
      r = '0;
    end else begin
      q = sn / sd;
      r = sn % sd;
    end
    return {r, q};
  endfunction

  function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    if (d == '0) return '0;
    return {n % d, n / d};
  endfunction

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               is_mul, is_div;
  logic [2*WIDTH-1:0] res;

  // Decode and result computation; a zero divisor re-commits the current HI/LO.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    res    = '0;
    case (bus.op)
      4'd1: begin is_mul = 1'b1; res = mul_signed(bus.a, bus.b); end
      4'd2: begin is_mul = 1'b1; res = mul_unsigned(bus.a, bus.b); end
      4'd3: begin
        is_div = 1'b1;
        res    = (bus.b == '0) ? {hi_q, lo_q} : div_signed(bus.a, bus.b);
      end
      4'd4: begin
        is_div = 1'b1;
        res    = (bus.b == '0) ? {hi_q, lo_q} : div_unsigned(bus.a, bus.b);
      end
`ifdef MDU_MADD_EN
      4'd7:  begin is_mul = 1'b1; res = {hi_q, lo_q} + mul_signed(bus.a, bus.b); end
      4'd8:  begin is_mul = 1'b1; res = {hi_q, lo_q} + mul_unsigned(bus.a, bus.b); end
      4'd9:  begin is_mul = 1'b1; res = {hi_q, lo_q} - mul_signed(bus.a, bus.b); end
      4'd10: begin is_mul = 1'b1; res = {hi_q, lo_q} - mul_unsigned(bus.a, bus.b); end
`endif
      default: ;
    endcase
  end

  // Next-state: count down while busy, otherwise accept a new op.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (bus.start) begin
      if (is_mul || is_div) begin
        pend_hi_d = res[2*WIDTH-1:WIDTH];
        pend_lo_d = res[WIDTH-1:0];
        cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        busy_d    = 1'b1;
      end else if (bus.op == 4'd5) begin
        hi_d = bus.a;
      end else if (bus.op == 4'd6) begin
        lo_d = bus.a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy = (bus.start & (is_mul | is_div)) | busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic results, divide-by-zero, reset cancel and ignored issue.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Issues one op and counts cycles with busy high; returns after busy drops.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 4'd0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    bus.start = 1'b1; bus.op = op; bus.a = val; bus.b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h expected 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h expected 00000000", bus.lo); end
  endtask

  task automatic test_mult();
    int n;
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
    vectors++; if (n !== 6) begin errors++; $display("FAIL mult_busy got %0d expected 6", n); end
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h expected ffffffff", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h expected fffffffa", bus.lo); end
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    vectors++; if (n !== 6) begin errors++; $display("FAIL multu_busy got %0d expected 6", n); end
    vectors++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h expected fffffffe", bus.hi); end
    vectors++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h expected 00000001", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    vectors++; if (n !== 11) begin errors++; $display("FAIL div_busy got %0d expected 11", n); end
    vectors++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h expected fffffffd", bus.lo); end
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h expected ffffffff", bus.hi); end
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, n);
    vectors++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo got %h expected fffffffd", bus.lo); end
    vectors++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL div_negb_hi got %h expected 00000001", bus.hi); end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    vectors++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h expected 80000000", bus.lo); end
    vectors++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got %h expected 00000000", bus.hi); end
    run_op(4'd4, 32'd100, 32'd7, n);
    vectors++; if (n !== 11) begin errors++; $display("FAIL divu_busy got %0d expected 11", n); end
    vectors++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h expected 0000000e", bus.lo); end
    vectors++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h expected 00000002", bus.hi); end
  endtask

  task automatic test_div_by_zero();
    int n;
    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    run_op(4'd4, 32'd7, 32'd0, n);
    vectors++; if (n !== 11) begin errors++; $display("FAIL divz_busy got %0d expected 11", n); end
    vectors++; if (bus.hi !== 32'h11) begin errors++; $display("FAIL divz_hi got %h expected 00000011", bus.hi); end
    vectors++; if (bus.lo !== 32'h22) begin errors++; $display("FAIL divz_lo got %h expected 00000022", bus.lo); end
  endtask

  task automatic test_mtlo();
    bus.start = 1'b1; bus.op = 4'd6; bus.a = 32'h1234;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy_issue got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'd0;
    @(negedge clk);
    vectors++; if (bus.lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got %h expected 00001234", bus.lo); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy_after got %b expected 0", bus.busy); end
    vectors++; if (bus.hi !== 32'h11) begin errors++; $display("FAIL mtlo_hi got %h expected 00000011", bus.hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy();
    mt(4'd5, 32'h77);
    bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 4'd5; bus.a = 32'hDEAD;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b expected 1", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'd0;
    @(negedge clk);
    vectors++; if (bus.hi !== 32'h77) begin errors++; $display("FAIL ign_hi_mid got %h expected 00000077", bus.hi); end
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end got %b expected 0", bus.busy); end
    vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL ign_hi got %h expected 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL ign_lo got %h expected 00000006", bus.lo); end
  endtask

  task automatic test_reset_mid();
    mt(4'd5, 32'h55);
    mt(4'd6, 32'h66);
    bus.start = 1'b1; bus.op = 4'd3; bus.a = 32'd9; bus.b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", bus.busy); end
    vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h expected 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h expected 00000000", bus.lo); end
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstmid_late_hi got %h expected 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_late_lo got %h expected 00000000", bus.lo); end
  endtask

  task automatic test_undef_op();
    mt(4'd5, 32'hAB);
    mt(4'd6, 32'hCD);
    bus.start = 1'b1; bus.op = 4'd15; bus.a = 32'h999; bus.b = 32'd4;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL undef_busy got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    bus.op = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++; if (bus.hi !== 32'hAB) begin errors++; $display("FAIL undef_hi got %h expected 000000ab", bus.hi); end
    vectors++; if (bus.lo !== 32'hCD) begin errors++; $display("FAIL undef_lo got %h expected 000000cd", bus.lo); end
  endtask

  task automatic test_madd();
    int n;
    mt(4'd5, 32'h0);
    mt(4'd6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op(4'd8, 32'd1, 32'd1, n);
    vectors++; if (n !== 6) begin errors++; $display("FAIL maddu_busy got %0d expected 6", n); end
    vectors++; if (bus.hi !== 32'h1) begin errors++; $display("FAIL maddu_hi got %h expected 00000001", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL maddu_lo got %h expected 00000000", bus.lo); end
    run_op(4'd9, 32'd2, 32'd3, n);
    vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL msub_hi got %h expected 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL msub_lo got %h expected fffffffa", bus.lo); end
`else
    run_op(4'd8, 32'd1, 32'd1, n);
    vectors++; if (n !== 0) begin errors++; $display("FAIL maddu_off_busy got %0d expected 0", n); end
    vectors++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL maddu_off_hi got %h expected 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL maddu_off_lo got %h expected ffffffff", bus.lo); end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    run_op(4'd2, 32'd10, 32'd20, n);
    run_op(4'd4, 32'd50, 32'd8, n);
    vectors++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL b2b_lo got %h expected 00000006", bus.lo); end
    vectors++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h expected 00000002", bus.hi); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 4'd0; bus.a = 32'd0; bus.b = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_mtlo();
    test_ignore_busy();
    test_reset_mid();
    test_undef_op();
    test_madd();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
